// File: rtl/router_pkt_reader_if.sv
// Handshake bundle between the router FIFO read side, the packet reader and its byte sink.
// master = packet reader, slave = FIFO/sink environment.
interface router_pkt_reader_if #(
  parameter int DATA_W = 8
);
  logic              empty;
  logic [DATA_W-1:0] dout;
  logic              sink_ready;
  logic              read_enb;
  logic [DATA_W-1:0] byte_out;
  logic              byte_valid;
  logic              pkt_done;
  logic [1:0]        pkt_addr;
  logic [5:0]        pkt_len;
  logic              parity_err;
  logic              pkt_abort;

  modport master (
    input  empty, dout, sink_ready,
    output read_enb, byte_out, byte_valid, pkt_done, pkt_addr, pkt_len, parity_err, pkt_abort
  );

  modport slave (
    output empty, dout, sink_ready,
    input  read_enb, byte_out, byte_valid, pkt_done, pkt_addr, pkt_len, parity_err, pkt_abort
  );
endinterface

// File: rtl/router_pkt_reader.sv
// Drains one router FIFO packet at a time (header, payload, parity), streams payload, flags errors/aborts.
// Optional PKT_READER_STATS_EN adds packet/error/abort counters.
//   state | meaning
//   IDLE  | waiting to issue the header read
//   HDR   | header read in flight
//   PAY   | consuming payload bytes
//   PAR   | consuming the parity byte
module router_pkt_reader #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_reset,
  router_pkt_reader_if.master bus
`ifdef PKT_READER_STATS_EN
  ,
  output logic [15:0]         pkt_cnt,
  output logic [15:0]         err_cnt,
  output logic [15:0]         abort_cnt
`endif
);

  localparam int            TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2, PAR = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [6:0]        reads_left_q, reads_left_d;
  logic [5:0]        pay_left_q, pay_left_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] byte_out_q, byte_out_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              rd_q, rd_d;
  logic              byte_valid_q, byte_valid_d;
  logic              pkt_done_q, pkt_done_d;
  logic              parity_err_q, parity_err_d;
  logic              pkt_abort_q, pkt_abort_d;
  logic [1:0]        pkt_addr_q, pkt_addr_d;
  logic [5:0]        pkt_len_q, pkt_len_d;
  logic              hdr_early;
  logic              read_enb;

  // The parity byte landing frees one read slot so the next header can issue back-to-back.
  assign hdr_early = (state_q == PAR) && rd_q;
  assign read_enb  = !bus.empty && bus.sink_ready && ((reads_left_q != 7'd0) || hdr_early)
                     && !rst && !soft_reset;
  assign rd_d      = read_enb;

  always_comb begin
    state_d      = state_q;
    reads_left_d = reads_left_q;
    pay_left_d   = pay_left_q;
    acc_d        = acc_q;
    tmr_d        = tmr_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    pkt_done_d   = 1'b0;
    parity_err_d = parity_err_q;
    pkt_abort_d  = 1'b0;
    pkt_addr_d   = pkt_addr_q;
    pkt_len_d    = pkt_len_q;
    if (read_enb && (reads_left_q != 7'd0)) reads_left_d = reads_left_q - 7'd1;
    if (soft_reset) begin
      pkt_abort_d  = (state_q != IDLE);
      state_d      = IDLE;
      reads_left_d = 7'd1;
    end else begin
      case (state_q)
        IDLE: begin
          if (read_enb) begin
            state_d = HDR;
            tmr_d   = TMR_LOAD;
          end
        end
        default: begin
          if (rd_q) begin
            tmr_d = TMR_LOAD;
            case (state_q)
              HDR: begin
                pkt_addr_d   = bus.dout[1:0];
                pkt_len_d    = bus.dout[7:2];
                acc_d        = bus.dout;
                pay_left_d   = bus.dout[7:2];
                reads_left_d = {1'b0, bus.dout[7:2]} + 7'd1;
                state_d      = (bus.dout[7:2] == 6'd0) ? PAR : PAY;
              end
              PAY: begin
                byte_out_d   = bus.dout;
                byte_valid_d = 1'b1;
                acc_d        = acc_q ^ bus.dout;
                pay_left_d   = pay_left_q - 6'd1;
                if (pay_left_q == 6'd1) state_d = PAR;
              end
              default: begin
                pkt_done_d   = 1'b1;
                parity_err_d = (acc_q != bus.dout);
                if (read_enb) begin
                  state_d      = HDR;
                  reads_left_d = 7'd0;
                end else begin
                  state_d      = IDLE;
                  reads_left_d = 7'd1;
                end
              end
            endcase
          end else if (tmr_q == TW'(1)) begin
            pkt_abort_d  = 1'b1;
            state_d      = IDLE;
            reads_left_d = 7'd1;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      reads_left_q <= 7'd1;
      pay_left_q   <= 6'd0;
      acc_q        <= '0;
      tmr_q        <= '0;
      rd_q         <= 1'b0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      pkt_abort_q  <= 1'b0;
      pkt_addr_q   <= 2'd0;
      pkt_len_q    <= 6'd0;
    end else begin
      state_q      <= state_d;
      reads_left_q <= reads_left_d;
      pay_left_q   <= pay_left_d;
      acc_q        <= acc_d;
      tmr_q        <= tmr_d;
      rd_q         <= rd_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      pkt_done_q   <= pkt_done_d;
      parity_err_q <= parity_err_d;
      pkt_abort_q  <= pkt_abort_d;
      pkt_addr_q   <= pkt_addr_d;
      pkt_len_q    <= pkt_len_d;
    end
  end

  assign bus.read_enb   = read_enb;
  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.pkt_done   = pkt_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.pkt_abort  = pkt_abort_q;
  assign bus.pkt_addr   = pkt_addr_q;
  assign bus.pkt_len    = pkt_len_q;

`ifdef PKT_READER_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] abort_cnt_q, abort_cnt_d;

  always_comb begin
    pkt_cnt_d   = pkt_cnt_q + {15'd0, pkt_done_d};
    err_cnt_d   = err_cnt_q + {15'd0, pkt_done_d && parity_err_d};
    abort_cnt_d = abort_cnt_q + {15'd0, pkt_abort_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= 16'd0;
      err_cnt_q   <= 16'd0;
      abort_cnt_q <= 16'd0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_router_pkt_reader.sv
// Directed bench for router_pkt_reader: FIFO model, byte sink monitor, hand-computed packet checks.
// Build with PKT_READER_STATS_EN to also check the statistics counters.
module tb_router_pkt_reader;
  localparam int TIMEOUT = 30;

  logic clk = 1'b0;
  logic rst;
  logic soft_reset;
  always #5 clk = ~clk;

  router_pkt_reader_if #(.DATA_W(8)) bus ();

`ifdef PKT_READER_STATS_EN
  logic [15:0] pkt_cnt, err_cnt, abort_cnt;
`endif

  router_pkt_reader #(.DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_reset (soft_reset),
    .bus        (bus)
`ifdef PKT_READER_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt),
    .abort_cnt  (abort_cnt)
`endif
  );

  // FIFO model: data appears on dout the cycle after read_enb
  logic [7:0] mem [0:511];
  int         wr_n = 0;
  int         rd_n = 0;
  logic       hold_empty = 1'b0;

  assign bus.empty = hold_empty || (wr_n == rd_n);

  always @(posedge clk) begin
    if (bus.read_enb) begin
      bus.dout <= mem[rd_n[8:0]];
      rd_n     <= rd_n + 1;
    end
  end

  int         cyc = 0;
  int         done_n = 0;
  int         abort_n = 0;
  int         abort_cyc = 0;
  int         last_re_cyc = 0;
  int         re_win = 0;
  int         bad_rd = 0;
  logic       win = 1'b0;
  logic [7:0] rx_q [$];
  logic       perr_q [$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.byte_valid) rx_q.push_back(bus.byte_out);
    if (bus.pkt_done) begin
      done_n = done_n + 1;
      perr_q.push_back(bus.parity_err);
    end
    if (bus.pkt_abort) begin
      abort_n   = abort_n + 1;
      abort_cyc = cyc;
    end
    if (bus.read_enb) begin
      last_re_cyc = cyc;
      if (win) re_win = re_win + 1;
      if (wr_n == rd_n) bad_rd = bad_rd + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_n[8:0]] = b;
    wr_n++;
  endtask

  function automatic int rx_at(input int i);
    if (i < rx_q.size()) return int'(rx_q[i]);
    return -1;
  endfunction

  function automatic int perr_at(input int i);
    if (i < perr_q.size()) return int'(perr_q[i]);
    return -1;
  endfunction

  // which: 0 = packets done, 1 = bytes received, 2 = aborts
  task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
    int k = 0;
    int v;
    v = (which == 0) ? done_n : (which == 1) ? rx_q.size() : abort_n;
    while (v < target && k < budget) begin
      cycles(1);
      k++;
      v = (which == 0) ? done_n : (which == 1) ? rx_q.size() : abort_n;
    end
    check_eq(tag, v, target);
  endtask

  int base, r0, d0, a0, sr_cyc;
`ifdef PKT_READER_STATS_EN
  int p0, ab0;
`endif

  initial begin
    rst             = 1'b1;
    soft_reset      = 1'b0;
    bus.sink_ready  = 1'b1;
    // first packet sits in the FIFO while reset is held
    push(8'h39);
    for (int i = 0; i < 14; i++) push(8'(i));
    push(8'h38);
    cycles(3);
    check_eq("rst_read_enb", int'(bus.read_enb), 0);
    check_eq("rst_byte_valid", int'(bus.byte_valid), 0);
    check_eq("rst_pkt_done", int'(bus.pkt_done), 0);
    check_eq("rst_pkt_abort", int'(bus.pkt_abort), 0);
    check_eq("rst_parity_err", int'(bus.parity_err), 0);
    check_eq("rst_pkt_addr", int'(bus.pkt_addr), 0);
    check_eq("rst_pkt_len", int'(bus.pkt_len), 0);
    check_eq("rst_byte_out", int'(bus.byte_out), 0);
`ifdef PKT_READER_STATS_EN
    check_eq("rst_pkt_cnt", int'(pkt_cnt), 0);
    check_eq("rst_abort_cnt", int'(abort_cnt), 0);
`endif
    rst = 1'b0;

    // len 14, addr 1, good parity
    wait_cnt("p1_done", 0, 1, 200);
    cycles(2);
    check_eq("p1_rx_count", rx_q.size(), 14);
    for (int i = 0; i < 14; i++) check_eq($sformatf("p1_byte%0d", i), rx_at(i), i);
    check_eq("p1_parity_err", perr_at(0), 0);
    check_eq("p1_pkt_addr", int'(bus.pkt_addr), 1);
    check_eq("p1_pkt_len", int'(bus.pkt_len), 14);
    check_eq("p1_reads", rd_n, 16);

    // bad parity packet followed back-to-back by a good len-3 packet
    push(8'h39);
    for (int i = 0; i < 14; i++) push(8'(i));
    push(8'h07);
    push(8'h0D); push(8'hAA); push(8'hBB); push(8'hCC); push(8'hD0);
    wait_cnt("p2_done", 0, 3, 300);
    cycles(2);
    check_eq("p2_parity_err", perr_at(1), 1);
    check_eq("p2b_parity_err", perr_at(2), 0);
    check_eq("p2_rx_count", rx_q.size(), 31);
    check_eq("p2b_byte0", rx_at(28), 'hAA);
    check_eq("p2b_byte2", rx_at(30), 'hCC);
    check_eq("p2b_pkt_addr", int'(bus.pkt_addr), 1);
    check_eq("p2b_pkt_len", int'(bus.pkt_len), 3);
    check_eq("p2_reads", rd_n, 37);

    // zero-length packet
    r0 = rd_n;
    push(8'h02); push(8'h02);
    wait_cnt("p3_done", 0, 4, 100);
    cycles(3);
    check_eq("p3_reads", rd_n - r0, 2);
    check_eq("p3_no_bytes", rx_q.size(), 31);
    check_eq("p3_parity_err", perr_at(3), 0);
    check_eq("p3_pkt_addr", int'(bus.pkt_addr), 2);
    check_eq("p3_pkt_len", int'(bus.pkt_len), 0);

    // empty held, then sink backpressure, mid-payload
    base = rx_q.size();
    push(8'h29);
    for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
    push(8'h28);
    wait_cnt("p4_first4", 1, base + 4, 100);
    hold_empty = 1'b1;
    win        = 1'b1;
    cycles(5);
    hold_empty     = 1'b0;
    bus.sink_ready = 1'b0;
    cycles(3);
    bus.sink_ready = 1'b1;
    win            = 1'b0;
    wait_cnt("p4_done", 0, 5, 200);
    cycles(2);
    check_eq("p4_read_enb_held_low", re_win, 0);
    check_eq("p4_rx_count", rx_q.size(), base + 10);
    for (int i = 0; i < 10; i++) check_eq($sformatf("p4_byte%0d", i), rx_at(base + i), 'h10 + i);
    check_eq("p4_parity_err", perr_at(4), 0);
    check_eq("p4_no_abort", abort_n, 0);

    // header only, then the FIFO stays empty
    r0 = rd_n;
    d0 = done_n;
    push(8'h15);
    wait_cnt("p5_abort", 2, 1, 100);
    cycles(2);
    check_eq("p5_abort_latency", abort_cyc - last_re_cyc, TIMEOUT + 1);
    check_eq("p5_no_done", done_n, d0);
    check_eq("p5_reads", rd_n - r0, 1);
    base = rx_q.size();
    push(8'h0A); push(8'h05); push(8'h06); push(8'h09);
    wait_cnt("p5r_done", 0, d0 + 1, 100);
    cycles(2);
    check_eq("p5r_byte0", rx_at(base), 5);
    check_eq("p5r_byte1", rx_at(base + 1), 6);
    check_eq("p5r_parity_err", perr_at(d0), 0);
    check_eq("p5r_pkt_addr", int'(bus.pkt_addr), 2);
    check_eq("p5r_pkt_len", int'(bus.pkt_len), 2);

    // soft_reset after the 3rd payload byte
    base = rx_q.size();
    a0   = abort_n;
    d0   = done_n;
`ifdef PKT_READER_STATS_EN
    p0  = int'(pkt_cnt);
    ab0 = int'(abort_cnt);
`endif
    push(8'h19); push(8'h40); push(8'h41); push(8'h42);
    wait_cnt("p6_three_bytes", 1, base + 3, 100);
    soft_reset = 1'b1;
    sr_cyc     = cyc + 1;
    cycles(1);
    soft_reset = 1'b0;
    cycles(2);
    check_eq("p6_abort_count", abort_n, a0 + 1);
    check_eq("p6_abort_cycle", abort_cyc, sr_cyc + 1);
    check_eq("p6_no_done", done_n, d0);
    soft_reset = 1'b1;
    cycles(1);
    soft_reset = 1'b0;
    cycles(2);
    check_eq("p6_idle_soft_reset_no_abort", abort_n, a0 + 1);
    base = rx_q.size();
    push(8'h0E); push(8'h01); push(8'h02); push(8'h04); push(8'h09);
    wait_cnt("p6r_done", 0, d0 + 1, 100);
    cycles(2);
    check_eq("p6r_byte0", rx_at(base), 1);
    check_eq("p6r_byte2", rx_at(base + 2), 4);
    check_eq("p6r_parity_err", perr_at(d0), 0);
    check_eq("p6r_pkt_addr", int'(bus.pkt_addr), 2);
    check_eq("p6r_pkt_len", int'(bus.pkt_len), 3);
`ifdef PKT_READER_STATS_EN
    check_eq("p6_abort_cnt_delta", int'(abort_cnt) - ab0, 1);
    check_eq("p6_pkt_cnt_delta", int'(pkt_cnt) - p0, 1);
    check_eq("stats_pkt_cnt", int'(pkt_cnt), 7);
    check_eq("stats_err_cnt", int'(err_cnt), 1);
    check_eq("stats_abort_cnt", int'(abort_cnt), 2);
`endif
    check_eq("never_read_empty", bad_rd, 0);
    check_eq("total_reads", rd_n, wr_n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
